// File: rtl/tlb.sv
// ============================================================================
// Module   : tlb
// Purpose  : Fully associative TLB, flop storage, two combinational search
//            ports, one combinational read port and one synchronous write port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlb #(
  parameter int TLBNUM = 16
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [18:0] s0_vpn2,
  input  logic        s0_odd_page,
  input  logic [7:0]  s0_asid,
  output logic        s0_found,
  output logic [3:0]  s0_index,
  output logic [19:0] s0_pfn,
  output logic [2:0]  s0_c,
  output logic        s0_d,
  output logic        s0_v,

  input  logic [18:0] s1_vpn2,
  input  logic        s1_odd_page,
  input  logic [7:0]  s1_asid,
  output logic        s1_found,
  output logic [3:0]  s1_index,
  output logic [19:0] s1_pfn,
  output logic [2:0]  s1_c,
  output logic        s1_d,
  output logic        s1_v,

  input  logic        we,
  input  logic [3:0]  w_index,
  input  logic [18:0] w_vpn2,
  input  logic [7:0]  w_asid,
  input  logic        w_g,
  input  logic [19:0] w_pfn0,
  input  logic [2:0]  w_c0,
  input  logic        w_d0,
  input  logic        w_v0,
  input  logic [19:0] w_pfn1,
  input  logic [2:0]  w_c1,
  input  logic        w_d1,
  input  logic        w_v1,

  input  logic [3:0]  r_index,
  output logic [18:0] r_vpn2,
  output logic [7:0]  r_asid,
  output logic        r_g,
  output logic [19:0] r_pfn0,
  output logic [2:0]  r_c0,
  output logic        r_d0,
  output logic        r_v0,
  output logic [19:0] r_pfn1,
  output logic [2:0]  r_c1,
  output logic        r_d1,
  output logic        r_v1
);

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } entry_t;

  entry_t              entry_q [TLBNUM];
  entry_t              entry_d [TLBNUM];
  entry_t              wr_entry;
  logic [TLBNUM-1:0]   s0_match;
  logic [TLBNUM-1:0]   s1_match;
  logic [3:0]          s0_hit_idx;
  logic [3:0]          s1_hit_idx;
  entry_t              s0_hit;
  entry_t              s1_hit;
  entry_t              rd_entry;

  assign wr_entry = '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                      pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                      pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};

  // Reset wins over write; an out-of-range w_index matches no entry.
  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      entry_d[i] = entry_q[i];
      if (reset) begin
        entry_d[i] = '0;
      end else if (we && (int'(w_index) == i)) begin
        entry_d[i] = wr_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < TLBNUM; i++) begin
      entry_q[i] <= entry_d[i];
    end
  end

  // Valid bits are deliberately not part of the match.
  generate
    for (genvar gi = 0; gi < TLBNUM; gi++) begin : g_match
      assign s0_match[gi] = (entry_q[gi].vpn2 == s0_vpn2) &&
                            (entry_q[gi].g || (entry_q[gi].asid == s0_asid));
      assign s1_match[gi] = (entry_q[gi].vpn2 == s1_vpn2) &&
                            (entry_q[gi].g || (entry_q[gi].asid == s1_asid));
    end
  endgenerate

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    s0_hit_idx = '0;
    s1_hit_idx = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (s0_match[i]) s0_hit_idx = 4'(i);
      if (s1_match[i]) s1_hit_idx = 4'(i);
    end
  end

  assign s0_found = |s0_match;
  assign s1_found = |s1_match;
  assign s0_index = s0_hit_idx;
  assign s1_index = s1_hit_idx;

  always_comb begin
    s0_hit = '0;
    s1_hit = '0;
    if (s0_found) s0_hit = entry_q[s0_hit_idx];
    if (s1_found) s1_hit = entry_q[s1_hit_idx];
  end

  assign s0_pfn = s0_odd_page ? s0_hit.pfn1 : s0_hit.pfn0;
  assign s0_c   = s0_odd_page ? s0_hit.c1   : s0_hit.c0;
  assign s0_d   = s0_odd_page ? s0_hit.d1   : s0_hit.d0;
  assign s0_v   = s0_odd_page ? s0_hit.v1   : s0_hit.v0;

  assign s1_pfn = s1_odd_page ? s1_hit.pfn1 : s1_hit.pfn0;
  assign s1_c   = s1_odd_page ? s1_hit.c1   : s1_hit.c0;
  assign s1_d   = s1_odd_page ? s1_hit.d1   : s1_hit.d0;
  assign s1_v   = s1_odd_page ? s1_hit.v1   : s1_hit.v0;

  always_comb begin
    rd_entry = '0;
    if (int'(r_index) < TLBNUM) rd_entry = entry_q[r_index];
  end

  assign r_vpn2 = rd_entry.vpn2;
  assign r_asid = rd_entry.asid;
  assign r_g    = rd_entry.g;
  assign r_pfn0 = rd_entry.pfn0;
  assign r_c0   = rd_entry.c0;
  assign r_d0   = rd_entry.d0;
  assign r_v0   = rd_entry.v0;
  assign r_pfn1 = rd_entry.pfn1;
  assign r_c1   = rd_entry.c1;
  assign r_d1   = rd_entry.d1;
  assign r_v1   = rd_entry.v1;

endmodule

`default_nettype wire

// File: tb/tb_tlb.sv
// ============================================================================
// Module   : tb_tlb
// Purpose  : Scoreboard bench for tlb: directed scenarios plus random traffic
//            against an array-based reference of the TLB contents.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlb;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] s0_vpn2, s1_vpn2;
  logic        s0_odd_page, s1_odd_page;
  logic [7:0]  s0_asid, s1_asid;
  logic        s0_found, s1_found;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0]  s0_c, s1_c;
  logic        s0_d, s1_d, s0_v, s1_v;
  logic        we;
  logic [3:0]  w_index;
  logic [18:0] w_vpn2;
  logic [7:0]  w_asid;
  logic        w_g;
  logic [19:0] w_pfn0, w_pfn1;
  logic [2:0]  w_c0, w_c1;
  logic        w_d0, w_d1, w_v0, w_v1;
  logic [3:0]  r_index;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic        r_g;
  logic [19:0] r_pfn0, r_pfn1;
  logic [2:0]  r_c0, r_c1;
  logic        r_d0, r_d1, r_v0, r_v1;

  tlb #(.TLBNUM(16)) dut (
    .clk(clk), .reset(reset),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
    .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
    .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
  );

  always #5 clk = ~clk;

  // Reference entry, field order as listed for the storage word.
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } ent_t;

  typedef struct {
    string       name;
    logic [29:0] s0;
    logic [29:0] s1;
    logic [77:0] r;
  } exp_t;

  ent_t  model [16];
  exp_t  sb [$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // {found, index, pfn, c, d, v}; first matching entry in ascending order wins.
  function automatic logic [29:0] ref_search(input logic [18:0] vpn2,
                                             input logic odd,
                                             input logic [7:0] asid);
    for (int i = 0; i < 16; i++) begin
      if (model[i].vpn2 == vpn2 && (model[i].g || model[i].asid == asid)) begin
        if (odd)
          return {1'b1, 4'(i), model[i].pfn1, model[i].c1, model[i].d1, model[i].v1};
        else
          return {1'b1, 4'(i), model[i].pfn0, model[i].c0, model[i].d0, model[i].v0};
      end
    end
    return '0;
  endfunction

  task automatic step(input string name);
    exp_t e;
    e.name = name;
    e.s0   = ref_search(s0_vpn2, s0_odd_page, s0_asid);
    e.s1   = ref_search(s1_vpn2, s1_odd_page, s1_asid);
    e.r    = model[r_index];
    sb.push_back(e);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 16; i++) model[i] = '0;
    end else if (we) begin
      model[w_index] = {w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
                        w_pfn1, w_c1, w_d1, w_v1};
    end
    #1;
  endtask

  task automatic set_wr(input logic [3:0] idx, input logic [18:0] vpn2,
                        input logic [7:0] asid, input logic g,
                        input logic [19:0] pfn0, input logic [2:0] c0,
                        input logic d0, input logic v0,
                        input logic [19:0] pfn1, input logic [2:0] c1,
                        input logic d1, input logic v1);
    we = 1'b1; w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
    w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
    w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
  endtask

  task automatic srch(input int port, input logic [18:0] vpn2,
                      input logic odd, input logic [7:0] asid);
    if (port == 0) begin
      s0_vpn2 = vpn2; s0_odd_page = odd; s0_asid = asid;
    end else begin
      s1_vpn2 = vpn2; s1_odd_page = odd; s1_asid = asid;
    end
  endtask

  task automatic check(input string name, input logic [77:0] got,
                       input logic [77:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: outputs are combinational, so a result is presented every cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".s0"}, 78'({s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v}), 78'(e.s0));
      check({e.name, ".s1"}, 78'({s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v}), 78'(e.s1));
      check({e.name, ".r"}, {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
                             r_pfn1, r_c1, r_d1, r_v1}, e.r);
    end
  end

  logic [18:0] vpool [5];
  logic [7:0]  apool [4];

  initial begin
    reset = 1'b1;
    set_wr(4'd0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    we = 1'b0;
    srch(0, 19'h0, 1'b0, 8'h0);
    srch(1, 19'h0, 1'b1, 8'h0);
    r_index = 4'd0;
    @(posedge clk);
    for (int i = 0; i < 16; i++) model[i] = '0;
    #1;

    // Cleared tags match a zero search.
    step("reset_zero_hit");
    reset = 1'b0;

    srch(0, 19'h12345, 1'b0, 8'h01);
    step("miss_after_reset");

    set_wr(4'd3, 19'h12345, 8'h05, 1'b0, 20'hABCDE, 3'd3, 1'b1, 1'b1,
           20'h11111, 3'd0, 1'b0, 1'b1);
    step("write_idx3");
    we = 1'b0;
    srch(1, 19'h12345, 1'b1, 8'h05); r_index = 4'd3;
    step("s1_odd_hit");
    srch(1, 19'h12345, 1'b0, 8'h05);
    step("s1_even_hit");
    srch(1, 19'h12345, 1'b0, 8'h06);
    step("s1_asid_miss");

    set_wr(4'd7, 19'h00400, 8'h20, 1'b1, 20'h00777, 3'd2, 1'b0, 1'b1,
           20'h00778, 3'd5, 1'b1, 1'b0);
    step("write_idx7_global");
    we = 1'b0;
    srch(0, 19'h00400, 1'b1, 8'h99); r_index = 4'd7;
    step("global_hit");

    srch(0, 19'h12345, 1'b1, 8'h05);
    set_wr(4'd3, 19'h2AAAA, 8'h05, 1'b0, 20'h22222, 3'd1, 1'b0, 1'b1,
           20'h33333, 3'd4, 1'b1, 1'b1);
    step("same_cycle_old");
    we = 1'b0;
    step("next_cycle_old_miss");
    srch(0, 19'h2AAAA, 1'b1, 8'h05);
    step("next_cycle_new_hit");

    set_wr(4'd9, 19'h0BEEF, 8'h33, 1'b0, 20'h99990, 3'd6, 1'b1, 1'b0,
           20'h99991, 3'd7, 1'b0, 1'b1);
    step("write_idx9");
    set_wr(4'd2, 19'h0BEEF, 8'h33, 1'b0, 20'h22220, 3'd1, 1'b0, 1'b1,
           20'h22221, 3'd2, 1'b1, 1'b0);
    step("write_idx2");
    we = 1'b0;
    srch(0, 19'h0BEEF, 1'b0, 8'h33); srch(1, 19'h0BEEF, 1'b1, 8'h33);
    r_index = 4'd9;
    step("multi_hit_lowest");

    reset = 1'b1;
    set_wr(4'd5, 19'h7FFFF, 8'hFF, 1'b1, 20'hFFFFF, 3'd7, 1'b1, 1'b1,
           20'hFFFFF, 3'd7, 1'b1, 1'b1);
    step("reset_beats_write");
    reset = 1'b0; we = 1'b0; r_index = 4'd5;
    srch(0, 19'h7FFFF, 1'b0, 8'hFF);
    step("after_reset_read5");

    vpool = '{19'h12345, 19'h2AAAA, 19'h00400, 19'h7FFFF, 19'h00000};
    apool = '{8'h00, 8'h05, 8'h33, 8'hFF};
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      we    = ($urandom_range(0, 1) == 1);
      w_index = 4'($urandom_range(0, 15));
      w_vpn2  = vpool[$urandom_range(0, 4)];
      w_asid  = apool[$urandom_range(0, 3)];
      w_g     = ($urandom_range(0, 3) == 0);
      w_pfn0 = 20'($urandom); w_c0 = 3'($urandom); w_d0 = 1'($urandom); w_v0 = 1'($urandom);
      w_pfn1 = 20'($urandom); w_c1 = 3'($urandom); w_d1 = 1'($urandom); w_v1 = 1'($urandom);
      srch(0, ($urandom_range(0, 7) == 0) ? 19'($urandom) : vpool[$urandom_range(0, 4)],
           1'($urandom), apool[$urandom_range(0, 3)]);
      srch(1, vpool[$urandom_range(0, 4)], 1'($urandom), apool[$urandom_range(0, 3)]);
      r_index = 4'($urandom_range(0, 15));
      step("random");
    end
    reset = 1'b0; we = 1'b0;

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tlb.md
TLB -- requirements
Module: tlb

Interface
REQ-001 TLBNUM, 16, number of entries; index ports are 4 bits wide.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 s0_vpn2 / s1_vpn2  in  19  search VPN2 (VA[31:13]); port 0 serves fetch, port 1 serves data access and tlbp.
REQ-005 s0_odd_page / s1_odd_page  in  1  VA[12]; selects the odd or even page.
REQ-006 s0_asid / s1_asid  in  8  search ASID.
REQ-007 s0_found / s1_found  out  1  hit flag.
REQ-008 s0_index / s1_index  out  4  index of the hit entry.
REQ-009 s0_pfn / s1_pfn  out  20; s0_c / s1_c  out  3; s0_d / s1_d, s0_v / s1_v  out  1  attributes of the selected page.
REQ-010 we  in  1  write strobe (tlbwi from writeback).
REQ-011 w_index  in  4  entry to write.
REQ-012 w_vpn2  in  19; w_asid  in  8; w_g  in  1  tag fields to write.
REQ-013 w_pfn0 / w_pfn1  in  20; w_c0 / w_c1  in  3; w_d0 / w_d1, w_v0 / w_v1  in  1  even and odd page fields.
REQ-014 r_index  in  4  entry to read (tlbr).
REQ-015 r_vpn2  out  19; r_asid  out  8; r_g  out  1; r_pfn0 / r_pfn1  out  20; r_c0 / r_c1  out  3; r_d0 / r_d1 / r_v0 / r_v1  out  1  read fields.

Function
REQ-016 Storage SHALL be TLBNUM entries of {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1} (78 bits each), held in flops, not RAM.
REQ-017 Write: at a clk edge with we=1 and reset=0, all fields of entry[w_index] SHALL be replaced and all other entries SHALL be unchanged.
- Write latency: 1 cycle; new contents are visible to search and read in the next cycle.
REQ-018 Search SHALL be combinational in the same cycle: match[i] = (vpn2[i]==s_vpn2) && (g[i] || asid[i]==s_asid).
- The v bits SHALL NOT gate match.
REQ-019 found = OR of all match[i]; index = lowest i with match[i]=1.
- On a miss: index=0 and pfn/c/d/v=0.
REQ-020 Page select: odd_page=1 SHALL return pfn1/c1/d1/v1 of the hit entry; odd_page=0 SHALL return pfn0/c0/d0/v0.
REQ-021 Multiple hits (software error) SHALL resolve deterministically to the lowest index, with no other side effect.
REQ-022 Read: r_* SHALL equal entry[r_index] combinationally, in the same cycle.
REQ-023 Write and search/read of the same entry in the same cycle SHALL return the old contents (no bypass); the new contents appear next cycle.
REQ-024 Ports s0, s1 and r SHALL be fully independent and may address the same entry simultaneously.
REQ-025 There is no handshake; the caller qualifies we.
- A single-cycle pulse SHALL produce exactly one write.
- we held high SHALL rewrite entry[w_index] every cycle.
REQ-026 If TLBNUM<16: writes with w_index>=TLBNUM SHALL be ignored; reads and indices beyond TLBNUM SHALL return 0.

Reset
REQ-027 A clk edge with reset=1 SHALL clear every field of every entry to 0.
- Reset has priority over we.
REQ-028 After reset, a search with vpn2=0 and asid=0 SHALL report found=1, index=0, v=0 (all-zero tags match); the v=0 result yields an invalid exception upstream.
REQ-029 After the first reset edge, all outputs SHALL be a pure function of the cleared state and the inputs; no output register exists.

Verification
REQ-030 Reset; s0 search vpn2=0x12345, asid=0x01 -> s0_found=0, s0_index=0, s0_pfn=0.
REQ-031 Write idx3 {vpn2=0x12345, asid=0x05, g=0, pfn0=0xABCDE, c0=3, d0=1, v0=1, pfn1=0x11111, v1=1}; next cycle:
- s1 search odd=1, asid=0x05 -> found=1, index=3, pfn=0x11111, v=1.
- s1 search odd=0 -> pfn=0xABCDE, c=3.
- s1 search asid=0x06 -> found=0.
REQ-032 Write idx7 {vpn2=0x00400, asid=0x20, g=1}; search vpn2=0x00400, asid=0x99 -> found=1, index=7.
REQ-033 Write idx3 with vpn2=0x2AAAA while s0 searches 0x12345 in the same cycle:
- That cycle -> found=1, index=3 (old contents).
- Next cycle, same search -> found=0; search 0x2AAAA -> found=1.
REQ-034 Entries 2 and 9 written with identical tags -> search index=2; r_index=9 returns entry 9 fields exactly.
REQ-035 reset=1 and we=1 (idx5, vpn2=0x7FFFF) on the same edge -> r_index=5 returns all zeros.
